// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: slot-owner encoding and screen bank defaults.
package common;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_SCR  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_t;

    localparam logic [2:0] SCR_BANK_NORM_DEFAULT   = 3'd5;
    localparam logic [2:0] SCR_BANK_SHADOW_DEFAULT = 3'd7;

    // Screen fetches always fall in the low 128K: 16K bank number plus offset.
    function automatic logic [18:0] scr_phys_addr(input logic [2:0] bank, input logic [13:0] offs);
        return {2'b00, bank, offs};
    endfunction

endpackage

// File: rtl/vram_arb_prio.sv
// Combinational slot-winner selection with DMA starvation ageing.
module vram_arb_prio
    import common::*;
#(
    parameter int DMA_MAX_WAIT = 4,
    parameter int AGE_W        = 3
) (
    input  logic             scr_req,
    input  logic             cpu_req,
    input  logic             dma_req,
    input  logic [AGE_W-1:0] age,
    output owner_t           owner_next,
    output logic [AGE_W-1:0] age_next
);

    logic dma_starved;

    assign dma_starved = (age >= AGE_W'(DMA_MAX_WAIT));

    always_comb begin
        owner_next = OWN_IDLE;
        age_next   = age;

        if (scr_req) begin
            owner_next = OWN_SCR;
        end else if (dma_req && dma_starved) begin
            owner_next = OWN_DMA;
        end else if (cpu_req) begin
            owner_next = OWN_CPU;
        end else if (dma_req) begin
            owner_next = OWN_DMA;
        end

        // Losing to the screen never ages DMA; only CPU wins count against it.
        if (owner_next == OWN_DMA) begin
            age_next = '0;
        end else if (owner_next == OWN_CPU && dma_req && !dma_starved) begin
            age_next = age + 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Slot sequencer sharing the external SRAM between screen, CPU and DMA; one access per ck14 slot.
module vram_arbiter
    import common::*;
#(
    parameter int         DMA_MAX_WAIT    = 4,
    parameter logic [2:0] SCR_BANK_NORM   = SCR_BANK_NORM_DEFAULT,
    parameter logic [2:0] SCR_BANK_SHADOW = SCR_BANK_SHADOW_DEFAULT
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        ck14,
    input  logic        scr_req,
    input  logic [14:0] scr_addr,
    input  logic        scr_page,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [18:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [18:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        cpu_ack,
    output logic        dma_ack,
    output logic [7:0]  rdata,
    output logic        clkwait,
    output logic [1:0]  owner
);

    localparam int AGE_W = $clog2(DMA_MAX_WAIT + 1);

    owner_t            owner_q, owner_d, arb_owner;
    logic [AGE_W-1:0]  age_q, age_d, arb_age;
    logic [18:0]       mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              clkwait_q, clkwait_d;
    logic              unused_scr_addr_msb;

    assign unused_scr_addr_msb = scr_addr[14];

    vram_arb_prio #(
        .DMA_MAX_WAIT (DMA_MAX_WAIT),
        .AGE_W        (AGE_W)
    ) u_prio (
        .scr_req    (scr_req),
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .age        (age_q),
        .owner_next (arb_owner),
        .age_next   (arb_age)
    );

    always_comb begin
        owner_d     = owner_q;
        age_d       = age_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        rdata_d     = rdata_q;

        if (ck14) begin
            // Close the slot that is ending, then latch everything for the next one.
            cpu_ack_d = (owner_q == OWN_CPU);
            dma_ack_d = (owner_q == OWN_DMA);
            if ((owner_q == OWN_CPU || owner_q == OWN_DMA) && mem_rd_q) begin
                rdata_d = mem_rdata;
            end

            owner_d  = arb_owner;
            age_d    = arb_age;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;

            unique case (arb_owner)
                OWN_SCR: begin
                    mem_addr_d = scr_phys_addr(scr_page ? SCR_BANK_SHADOW : SCR_BANK_NORM,
                                               scr_addr[13:0]);
                    mem_rd_d   = 1'b1;
                end
                OWN_CPU: begin
                    mem_addr_d = cpu_addr;
                    mem_rd_d   = !cpu_we;
                    mem_wr_d   = cpu_we;
                    if (cpu_we) begin
                        mem_wdata_d = cpu_wdata;
                    end
                end
                OWN_DMA: begin
                    mem_addr_d = dma_addr;
                    mem_rd_d   = !dma_we;
                    mem_wr_d   = dma_we;
                    if (dma_we) begin
                        mem_wdata_d = dma_wdata;
                    end
                end
                default: begin
                end
            endcase
        end

        // Evaluated on next-state values so clkwait lines up with owner and cpu_ack.
        clkwait_d = cpu_req && (owner_d != OWN_CPU) && !cpu_ack_d;
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            owner_q     <= OWN_IDLE;
            age_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            rdata_q     <= '0;
            clkwait_q   <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            age_q       <= age_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            rdata_q     <= rdata_d;
            clkwait_q   <= clkwait_d;
        end
    end

    assign owner     = owner_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign rdata     = rdata_q;
    assign clkwait   = clkwait_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scenario tests plus a randomized run against a slot-level reference model of the arbiter.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk28 = 1'b0;
    logic        rst = 1'b1;
    logic        ck14 = 1'b0;
    logic        scr_req = 1'b0;
    logic [14:0] scr_addr = '0;
    logic        scr_page = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [18:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic [7:0]  mem_rdata = '0;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd, mem_wr, cpu_ack, dma_ack, clkwait;
    logic [7:0]  rdata;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (slot-level view)
    int          m_owner, m_age;
    bit          m_we;
    logic [18:0] e_addr;
    logic [7:0]  e_wdata, e_rdata;
    bit          e_rd, e_wr, e_cpu_ack, e_dma_ack, e_clkwait;

    always #5 clk28 = ~clk28;

    vram_arbiter dut (
        .clk28(clk28), .rst(rst), .ck14(ck14),
        .scr_req(scr_req), .scr_addr(scr_addr), .scr_page(scr_page),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
        .rdata(rdata), .clkwait(clkwait), .owner(owner)
    );

    task automatic arb_edge();
        ck14 = 1'b1;
        @(negedge clk28);
        ck14 = 1'b0;
    endtask

    task automatic mid_edge();
        @(negedge clk28);
    endtask

    task automatic model_reset();
        m_owner = 0; m_age = 0; m_we = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
        e_rd = 0; e_wr = 0; e_cpu_ack = 0; e_dma_ack = 0; e_clkwait = 0;
    endtask

    // One arbitration: finish the old slot, pick the new owner by the priority rules.
    task automatic model_step();
        int w;
        e_cpu_ack = (m_owner == 2);
        e_dma_ack = (m_owner == 3);
        if ((e_cpu_ack || e_dma_ack) && !m_we) e_rdata = mem_rdata;
        if (scr_req)                           w = 1;
        else if (dma_req && m_age >= MAX_WAIT) w = 3;
        else if (cpu_req)                      w = 2;
        else if (dma_req)                      w = 3;
        else                                   w = 0;
        if (w == 3) m_age = 0;
        else if (w == 2 && dma_req) m_age = (m_age + 1 > MAX_WAIT) ? MAX_WAIT : m_age + 1;
        m_owner = w;
        e_rd = 0; e_wr = 0;
        if (w == 1) begin
            e_addr = 19'((scr_page ? 7 : 5) * 16384 + (int'(scr_addr) % 16384));
            e_rd = 1; m_we = 0;
        end else if (w == 2) begin
            e_addr = cpu_addr; m_we = cpu_we; e_rd = !cpu_we; e_wr = cpu_we;
            if (cpu_we) e_wdata = cpu_wdata;
        end else if (w == 3) begin
            e_addr = dma_addr; m_we = dma_we; e_rd = !dma_we; e_wr = dma_we;
            if (dma_we) e_wdata = dma_wdata;
        end
        e_clkwait = cpu_req && (w != 2) && !e_cpu_ack;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk28);
        n_checks++;
        if ({owner, mem_addr, mem_wdata, mem_rd, mem_wr, cpu_ack, dma_ack, rdata, clkwait} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got owner=%0d addr=%h wdata=%h rd=%b wr=%b cack=%b dack=%b rdata=%h cw=%b, required all 0",
                     owner, mem_addr, mem_wdata, mem_rd, mem_wr, cpu_ack, dma_ack, rdata, clkwait);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            arb_edge();
            n_checks++;
            if ({owner, mem_rd, mem_wr, cpu_ack, dma_ack, clkwait} !== '0) begin
                n_errors++;
                $display("FAIL idle_slot %0d: owner=%0d rd=%b wr=%b cack=%b dack=%b cw=%b, required all 0",
                         i, owner, mem_rd, mem_wr, cpu_ack, dma_ack, clkwait);
            end
            mid_edge();
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h12345; mem_rdata = 8'h00;
        arb_edge();
        n_checks++;
        if (owner !== 2'd2 || mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 19'h12345) begin
            n_errors++;
            $display("FAIL cpu_read_grant: owner=%0d rd=%b wr=%b addr=%h, required 2 1 0 12345", owner, mem_rd, mem_wr, mem_addr);
        end
        n_checks++;
        if (clkwait !== 1'b0 || cpu_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL cpu_read_cw: clkwait=%b cack=%b, required 0 0", clkwait, cpu_ack);
        end
        cpu_req = 0; mem_rdata = 8'hA5;
        mid_edge();
        n_checks++;
        if (owner !== 2'd2) begin
            n_errors++;
            $display("FAIL cpu_read_hold: owner=%0d, required 2", owner);
        end
        arb_edge();
        n_checks++;
        if (cpu_ack !== 1'b1 || rdata !== 8'hA5 || owner !== 2'd0 || clkwait !== 1'b0 || mem_rd !== 1'b0) begin
            n_errors++;
            $display("FAIL cpu_read_ack: cack=%b rdata=%h owner=%0d cw=%b rd=%b, required 1 a5 0 0 0",
                     cpu_ack, rdata, owner, clkwait, mem_rd);
        end
        mid_edge();
        n_checks++;
        if (cpu_ack !== 1'b0 || rdata !== 8'hA5) begin
            n_errors++;
            $display("FAIL cpu_read_pulse: cack=%b rdata=%h, required 0 a5", cpu_ack, rdata);
        end
    endtask

    task automatic test_scr_cpu();
        int cw_high = 0;
        scr_req = 1; scr_addr = 15'h1800; scr_page = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00ABC; mem_rdata = 8'h11;
        arb_edge();
        cw_high += int'(clkwait);
        n_checks++;
        if (owner !== 2'd1 || mem_addr !== 19'h1D800 || mem_rd !== 1'b1 || clkwait !== 1'b1) begin
            n_errors++;
            $display("FAIL scr_first: owner=%0d addr=%h rd=%b cw=%b, required 1 1d800 1 1", owner, mem_addr, mem_rd, clkwait);
        end
        scr_req = 0; scr_page = 0; scr_addr = 15'h0000;
        mid_edge();
        cw_high += int'(clkwait);
        n_checks++;
        if (mem_addr !== 19'h1D800 || clkwait !== 1'b1) begin
            n_errors++;
            $display("FAIL scr_latched: addr=%h cw=%b, required 1d800 1", mem_addr, clkwait);
        end
        arb_edge();
        cw_high += int'(clkwait);
        n_checks++;
        if (owner !== 2'd2 || mem_addr !== 19'h00ABC || clkwait !== 1'b0 || cpu_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL scr_then_cpu: owner=%0d addr=%h cw=%b cack=%b, required 2 00abc 0 0", owner, mem_addr, clkwait, cpu_ack);
        end
        cpu_req = 0; mem_rdata = 8'h3E;
        mid_edge();
        cw_high += int'(clkwait);
        arb_edge();
        cw_high += int'(clkwait);
        n_checks++;
        if (cpu_ack !== 1'b1 || rdata !== 8'h3E || owner !== 2'd0) begin
            n_errors++;
            $display("FAIL scr_cpu_ack: cack=%b rdata=%h owner=%0d, required 1 3e 0", cpu_ack, rdata, owner);
        end
        mid_edge();
        cw_high += int'(clkwait);
        n_checks++;
        if (cw_high != 2) begin
            n_errors++;
            $display("FAIL scr_cpu_clkwait_len: high for %0d clk28 cycles, required 2", cw_high);
        end
    endtask

    task automatic test_cpu_dma_continuous();
        int exp_own;
        int prev = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h01000;
        dma_req = 1; dma_we = 0; dma_addr = 19'h02000; mem_rdata = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            exp_own = (i % 5 == 4) ? 3 : 2;
            arb_edge();
            n_checks++;
            if (owner !== 2'(exp_own) || mem_addr !== ((exp_own == 3) ? 19'h02000 : 19'h01000)) begin
                n_errors++;
                $display("FAIL contend_owner slot %0d: owner=%0d addr=%h, required %0d", i, owner, mem_addr, exp_own);
            end
            n_checks++;
            if (cpu_ack !== (prev == 2) || dma_ack !== (prev == 3)) begin
                n_errors++;
                $display("FAIL contend_ack slot %0d: cack=%b dack=%b, required %b %b", i, cpu_ack, dma_ack, prev == 2, prev == 3);
            end
            prev = exp_own;
            mid_edge();
        end
        cpu_req = 0; dma_req = 0;
        arb_edge();
        n_checks++;
        if (dma_ack !== 1'b1 || owner !== 2'd0 || rdata !== 8'h5A) begin
            n_errors++;
            $display("FAIL contend_drain: dack=%b owner=%0d rdata=%h, required 1 0 5a", dma_ack, owner, rdata);
        end
        mid_edge();
    endtask

    task automatic test_dma_write();
        int exp_own;
        int acks = 0;
        dma_req = 1; dma_we = 1; dma_addr = 19'h40000; dma_wdata = 8'h3C; mem_rdata = 8'hFF;
        scr_addr = 15'h0123; scr_page = 0;
        for (int i = 0; i < 8; i++) begin
            scr_req = (i % 2 == 0);
            exp_own = (i % 2 == 0) ? 1 : ((i == 1) ? 3 : 0);
            arb_edge();
            acks += int'(dma_ack);
            n_checks++;
            if (owner !== 2'(exp_own)) begin
                n_errors++;
                $display("FAIL dma_wr_owner slot %0d: owner=%0d, required %0d", i, owner, exp_own);
            end
            if (exp_own == 1) begin
                n_checks++;
                if (mem_wr !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 19'h14123) begin
                    n_errors++;
                    $display("FAIL dma_wr_scr slot %0d: wr=%b rd=%b addr=%h, required 0 1 14123", i, mem_wr, mem_rd, mem_addr);
                end
            end
            if (exp_own == 3) begin
                dma_req = 0;
                n_checks++;
                if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 19'h40000 || mem_wdata !== 8'h3C) begin
                    n_errors++;
                    $display("FAIL dma_wr_slot: wr=%b rd=%b addr=%h wdata=%h, required 1 0 40000 3c", mem_wr, mem_rd, mem_addr, mem_wdata);
                end
            end
            mid_edge();
            if (exp_own == 3) begin
                n_checks++;
                if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin
                    n_errors++;
                    $display("FAIL dma_wr_whole_slot: wr=%b rd=%b, required 1 0", mem_wr, mem_rd);
                end
            end
        end
        scr_req = 0;
        n_checks++;
        if (acks != 1 || rdata !== 8'h5A) begin
            n_errors++;
            $display("FAIL dma_wr_ack: acks=%0d rdata=%h, required 1 5a", acks, rdata);
        end
    endtask

    task automatic test_reset_mid();
        bit acked = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00777; mem_rdata = 8'h99;
        arb_edge();
        n_checks++;
        if (owner !== 2'd2) begin
            n_errors++;
            $display("FAIL rstmid_grant: owner=%0d, required 2", owner);
        end
        rst = 1;
        @(negedge clk28);
        n_checks++;
        if ({owner, mem_rd, mem_wr, mem_addr, rdata, cpu_ack, clkwait} !== '0) begin
            n_errors++;
            $display("FAIL rstmid_outputs: owner=%0d rd=%b addr=%h rdata=%h cack=%b cw=%b, required all 0",
                     owner, mem_rd, mem_addr, rdata, cpu_ack, clkwait);
        end
        @(negedge clk28);
        rst = 0;
        for (int i = 0; i < 4 && !acked; i++) begin
            arb_edge();
            if (i == 0) begin
                n_checks++;
                if (owner !== 2'd2 || cpu_ack !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rstmid_rearb: owner=%0d cack=%b, required 2 0", owner, cpu_ack);
                end
            end
            if (owner == 2'd2) cpu_req = 0;
            if (cpu_ack) begin
                acked = 1;
                n_checks++;
                if (rdata !== 8'h99) begin
                    n_errors++;
                    $display("FAIL rstmid_rdata: rdata=%h, required 99", rdata);
                end
            end
            mid_edge();
        end
        cpu_req = 0;
        n_checks++;
        if (!acked) begin
            n_errors++;
            $display("FAIL rstmid_timeout: cpu_ack=0 after 4 slots, required 1");
        end
    endtask

    task automatic test_random();
        bit saw_cack = 0, saw_dack = 0, saw_cown = 0;
        rst = 1;
        cpu_req = 0; dma_req = 0; scr_req = 0;
        repeat (2) @(negedge clk28);
        rst = 0;
        model_reset();
        for (int s = 0; s < 400; s++) begin
            if (!cpu_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 19'($urandom); cpu_wdata = 8'($urandom);
                end
            end else if (saw_cack) begin
                if ($urandom_range(1, 0) == 1) cpu_req = 0;
                else begin cpu_we = 1'($urandom); cpu_addr = 19'($urandom); cpu_wdata = 8'($urandom); end
            end else if (saw_cown && $urandom_range(3, 0) == 0) begin
                cpu_req = 0;
            end
            if (!dma_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    dma_req = 1; dma_we = 1'($urandom); dma_addr = 19'($urandom); dma_wdata = 8'($urandom);
                end
            end else if (saw_dack && $urandom_range(1, 0) == 1) begin
                dma_req = 0;
            end
            scr_req = ($urandom_range(2, 0) == 0);
            scr_page = 1'($urandom);
            scr_addr = 15'($urandom);
            mem_rdata = 8'($urandom);
            arb_edge();
            model_step();
            n_checks++;
            if (owner !== 2'(m_owner) || mem_rd !== e_rd || mem_wr !== e_wr || mem_addr !== e_addr) begin
                n_errors++;
                $display("FAIL rnd_slot %0d: owner=%0d rd=%b wr=%b addr=%h, required %0d %b %b %h",
                         s, owner, mem_rd, mem_wr, mem_addr, m_owner, e_rd, e_wr, e_addr);
            end
            n_checks++;
            if (cpu_ack !== e_cpu_ack || dma_ack !== e_dma_ack || rdata !== e_rdata || clkwait !== e_clkwait) begin
                n_errors++;
                $display("FAIL rnd_ack %0d: cack=%b dack=%b rdata=%h cw=%b, required %b %b %h %b",
                         s, cpu_ack, dma_ack, rdata, clkwait, e_cpu_ack, e_dma_ack, e_rdata, e_clkwait);
            end
            if (e_wr) begin
                n_checks++;
                if (mem_wdata !== e_wdata) begin
                    n_errors++;
                    $display("FAIL rnd_wdata %0d: wdata=%h, required %h", s, mem_wdata, e_wdata);
                end
            end
            saw_cack = cpu_ack; saw_dack = dma_ack; saw_cown = (owner == 2'd2);
            scr_page = 1'($urandom);
            scr_addr = 15'($urandom);
            mid_edge();
            n_checks++;
            if (owner !== 2'(m_owner) || mem_addr !== e_addr || cpu_ack !== 1'b0 || dma_ack !== 1'b0 || (mem_rd && mem_wr)) begin
                n_errors++;
                $display("FAIL rnd_mid %0d: owner=%0d addr=%h cack=%b dack=%b rd=%b wr=%b, required %0d %h 0 0",
                         s, owner, mem_addr, cpu_ack, dma_ack, mem_rd, mem_wr, m_owner, e_addr);
            end
        end
        cpu_req = 0; dma_req = 0; scr_req = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk28);
        test_reset();
        test_idle();
        test_cpu_read();
        test_scr_cpu();
        test_cpu_dma_continuous();
        test_dma_write();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
